sdram_arbiter: RTL and testbench

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

---
 rtl/sdram_arb_pkg.sv | 10 +
 rtl/sdram_arb_rr.sv | 17 +
 rtl/sdram_arbiter.sv | 123 ++++++++++++
 tb/tb_sdram_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: FSM states, grant codes and the default slot length.
// These are shared by the sdram_arbiter block.
package sdram_arb_pkg;
    typedef enum logic [1:0] {IDLE, SLOT, ACK} state_t;
    localparam logic [1:0] GNT_IDLE = 2'd0;
    localparam logic [1:0] GNT_DL   = 2'd1;
    localparam logic [1:0] GNT_CPU  = 2'd2;
    localparam logic [1:0] GNT_DMA  = 2'd3;
    localparam int SLOT_CYCLES_DEF = 8;
endpackage

// File: rtl/sdram_arb_rr.sv
// sdram_arb_rr: two-way cpu/dma round-robin pick plus its pointer register.
// The port served last loses a tie.
module sdram_arb_rr (
    input  logic clk,
    input  logic reset_n,
    input  logic cpu_req,
    input  logic dma_req,
    input  logic take,
    output logic pick_dma
);
    logic last_dma;
    assign pick_dma = dma_req && (!cpu_req || !last_dma);
    // Reset marks dma as last served, so cpu wins the first tie.
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) last_dma <= 1'b1;
        else if (take) last_dma <= pick_dma;
endmodule

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: slot-based arbiter for the download, cpu and dma ports in front of an SDRAM controller.
// Defining SDRAM_ARB_REFRESH_EN adds periodic refresh slots.
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W         = 25,
    parameter int SLOT_CYCLES    = SLOT_CYCLES_DEF,
    parameter int REFRESH_PERIOD = 250
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              dl_req,
    output logic              dl_ack,
    input  logic [ADDR_W-1:0] dl_addr,
    input  logic [7:0]        dl_data,
    input  logic              cpu_req,
    input  logic              cpu_we,
    output logic              cpu_ack,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic [7:0]        cpu_rdata,
    input  logic              dma_req,
    output logic              dma_ack,
    input  logic [ADDR_W-1:0] dma_addr,
    output logic [7:0]        dma_rdata,
    input  logic              downloading,
    output logic [ADDR_W-1:0] sd_addr,
    output logic [7:0]        sd_din,
    output logic              sd_we,
    output logic              sd_oe,
    input  logic [7:0]        sd_dout,
    output logic              sd_refresh,
    output logic [1:0]        grant
);
    state_t     state;
    logic [3:0] cnt;
    logic [1:0] win;
    logic       ref_due, pick_dma, start, slot_end;

    sdram_arb_rr u_rr (
        .clk      (clk),
        .reset_n  (reset_n),
        .cpu_req  (cpu_req),
        .dma_req  (dma_req),
        .take     (start && win[1]),
        .pick_dma (pick_dma)
    );

    // A refresh slot starts with win = GNT_IDLE, so it drives no strobes and produces no ack.
    assign win = ref_due ? GNT_IDLE
               : downloading ? (dl_req ? GNT_DL : GNT_IDLE)
               : (cpu_req || dma_req) ? (pick_dma ? GNT_DMA : GNT_CPU) : GNT_IDLE;
    assign start    = state == IDLE && (ref_due || win != GNT_IDLE);
    assign slot_end = state == SLOT && cnt == 4'(SLOT_CYCLES - 1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            grant     <= GNT_IDLE;
            sd_addr   <= '0;
            sd_din    <= '0;
            sd_we     <= 1'b0;
            sd_oe     <= 1'b0;
            dl_ack    <= 1'b0;
            cpu_ack   <= 1'b0;
            dma_ack   <= 1'b0;
            cpu_rdata <= '0;
            dma_rdata <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state   <= SLOT;
                    cnt     <= '0;
                    grant   <= win;
                    sd_addr <= win == GNT_DL ? dl_addr : win == GNT_CPU ? cpu_addr : dma_addr;
                    sd_din  <= win == GNT_DL ? dl_data : cpu_wdata;
                    sd_we   <= win == GNT_DL || (win == GNT_CPU && cpu_we);
                    sd_oe   <= win == GNT_DMA || (win == GNT_CPU && !cpu_we);
                end
                SLOT: begin
                    cnt <= cnt + 1'b1;
                    if (slot_end) begin
                        state   <= ACK;
                        sd_we   <= 1'b0;
                        sd_oe   <= 1'b0;
                        dl_ack  <= grant == GNT_DL;
                        cpu_ack <= grant == GNT_CPU;
                        dma_ack <= grant == GNT_DMA;
                        if (sd_oe && grant == GNT_CPU) cpu_rdata <= sd_dout;
                        if (sd_oe && grant == GNT_DMA) dma_rdata <= sd_dout;
                    end
                end
                default: begin
                    state   <= IDLE;
                    grant   <= GNT_IDLE;
                    dl_ack  <= 1'b0;
                    cpu_ack <= 1'b0;
                    dma_ack <= 1'b0;
                end
            endcase
        end
    end

`ifdef SDRAM_ARB_REFRESH_EN
    logic [15:0] ref_cnt;
    assign ref_due = ref_cnt >= 16'(REFRESH_PERIOD);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ref_cnt    <= '0;
            sd_refresh <= 1'b0;
        end else begin
            ref_cnt <= (start && ref_due) ? '0 : ref_due ? ref_cnt : ref_cnt + 1'b1;
            if (start && ref_due) sd_refresh <= 1'b1;
            else if (slot_end) sd_refresh <= 1'b0;
        end
    end
`else
    assign ref_due = 1'b0;
    // Refresh is disabled; the period parameter is kept so both builds share one parameter list.
    assign sd_refresh = 1'b0 && REFRESH_PERIOD != 0;
`endif
endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: the driver tasks push the expected slots into a queue.
// A negedge monitor pops and checks an expected slot on every ack and also watches refresh slots.
module tb_sdram_arbiter;
    import sdram_arb_pkg::*;
    localparam int AW = 25, SC = 8, RP = 20;

    logic clk = 1'b0, reset_n = 1'b0, downloading = 1'b0;
    logic dl_req = 1'b0, cpu_req = 1'b0, cpu_we = 1'b0, dma_req = 1'b0;
    logic [AW-1:0] dl_addr = '0, cpu_addr = '0, dma_addr = '0;
    logic [7:0] dl_data = '0, cpu_wdata = '0;
    logic dl_ack, cpu_ack, dma_ack, sd_we, sd_oe, sd_refresh;
    logic [7:0] cpu_rdata, dma_rdata, sd_din, sd_dout;
    logic [AW-1:0] sd_addr;
    logic [1:0] grant;

    sdram_arbiter #(.ADDR_W(AW), .SLOT_CYCLES(SC), .REFRESH_PERIOD(RP)) dut (
        .clk(clk), .reset_n(reset_n),
        .dl_req(dl_req), .dl_ack(dl_ack), .dl_addr(dl_addr), .dl_data(dl_data),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_ack(cpu_ack), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_ack(dma_ack), .dma_addr(dma_addr), .dma_rdata(dma_rdata),
        .downloading(downloading),
        .sd_addr(sd_addr), .sd_din(sd_din), .sd_we(sd_we), .sd_oe(sd_oe),
        .sd_dout(sd_dout), .sd_refresh(sd_refresh), .grant(grant)
    );

    always #5 clk = ~clk;
    // The SDRAM model returns the low address byte XOR 0x3C, so address 0x100 reads back 0x3C.
    assign sd_dout = sd_addr[7:0] ^ 8'h3C;

    typedef struct {
        logic [1:0]    port;
        logic [AW-1:0] addr;
        logic          we;
        logic [7:0]    data;
    } exp_t;
    exp_t q[$];
    int checks = 0, errors = 0;
    int cyc = 0, run = 0, rrun = 0, nref = 0, ref_hi = 0, last_ref = 0;
    logic [AW-1:0] s_addr;
    logic [7:0] s_din;
    logic s_we, stable;
    logic [1:0] s_gnt;
    exp_t m;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", n, act, exp, $time);
        end
    endtask

    task automatic push(input logic [1:0] p, input logic [AW-1:0] a, input logic w, input logic [7:0] d);
        exp_t e;
        e.port = p; e.addr = a; e.we = w; e.data = d;
        q.push_back(e);
    endtask

    task automatic xfer(input logic [1:0] p, input logic [AW-1:0] a, input logic w,
                        input logic [7:0] d, output int lat);
        logic got;
        got = 1'b0;
        lat = 0;
        if (p == GNT_DL) begin dl_addr = a; dl_data = d; dl_req = 1'b1; end
        else if (p == GNT_CPU) begin cpu_addr = a; cpu_we = w; cpu_wdata = d; cpu_req = 1'b1; end
        else begin dma_addr = a; dma_req = 1'b1; end
        while (!got && lat < 400) begin
            @(posedge clk); #1;
            lat++;
            got = p == GNT_DL ? dl_ack : p == GNT_CPU ? cpu_ack : dma_ack;
        end
        chk("ack_arrived", 32'(got), 32'd1);
        if (p == GNT_DL) dl_req = 1'b0;
        else if (p == GNT_CPU) cpu_req = 1'b0;
        else dma_req = 1'b0;
    endtask

    always @(negedge clk) begin
        cyc++;
        if (!reset_n) begin
            run = 0;
            rrun = 0;
        end else begin
            if (sd_refresh) begin
                ref_hi++;
                if (rrun == 0) begin
                    if (nref > 0) chk("refresh_spacing", 32'(cyc - last_ref >= RP), 32'd1);
                    last_ref = cyc;
                    nref++;
                end
                rrun++;
            end else if (rrun > 0) begin
                chk("refresh_len", 32'(rrun), 32'(SC));
                rrun = 0;
            end
            if (sd_we || sd_oe) begin
                if (run == 0) begin
                    s_addr = sd_addr; s_din = sd_din; s_we = sd_we; s_gnt = grant; stable = 1'b1;
                end else
                    stable = stable && sd_addr == s_addr && sd_din == s_din && sd_we == s_we && grant == s_gnt;
                run++;
            end
            if (dl_ack || cpu_ack || dma_ack) begin
                if (q.size() == 0) chk("unexpected_ack", 32'({dl_ack, cpu_ack, dma_ack}), 32'd0);
                else begin
                    m = q.pop_front();
                    chk("ack_port", dl_ack ? 32'd1 : cpu_ack ? 32'd2 : 32'd3, 32'(m.port));
                    chk("one_ack", 32'(dl_ack) + 32'(cpu_ack) + 32'(dma_ack), 32'd1);
                    chk("slot_grant", 32'(s_gnt), 32'(m.port));
                    chk("slot_addr", 32'(s_addr), 32'(m.addr));
                    chk("slot_dir", 32'(s_we), 32'(m.we));
                    chk("strobe_len", 32'(run), 32'(SC));
                    chk("slot_stable", 32'(stable), 32'd1);
                    chk(m.we ? "write_data" : "read_data",
                        32'(m.we ? s_din : m.port == GNT_CPU ? cpu_rdata : dma_rdata), 32'(m.data));
                end
                run = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat, l0, l1, l2, n, t, a;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_strobes", 32'({sd_we, sd_oe, sd_refresh}), 32'd0);
        chk("rst_acks", 32'({dl_ack, cpu_ack, dma_ack}), 32'd0);
        chk("rst_rdata", 32'({cpu_rdata, dma_rdata}), 32'd0);
        chk("rst_bus", 32'(sd_addr) | 32'(sd_din), 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // cpu write from an idle arbiter: ack on cycle SLOT_CYCLES+1
        push(GNT_CPU, 25'h100, 1'b1, 8'hA5);
        xfer(GNT_CPU, 25'h100, 1'b1, 8'hA5, lat);
        chk("cpu_latency", 32'(lat), 32'(SC + 1));
        push(GNT_CPU, 25'h100, 1'b0, 8'h3C);
        xfer(GNT_CPU, 25'h100, 1'b0, 8'h00, lat);
        chk("dma_rdata_kept", 32'(dma_rdata), 32'd0);
        push(GNT_DMA, 25'h2043, 1'b0, 8'h7F);
        xfer(GNT_DMA, 25'h2043, 1'b0, 8'h00, lat);
        chk("cpu_rdata_kept", 32'(cpu_rdata), 32'h3C);

        // both held: dma served last, so cpu first, then alternate
        push(GNT_CPU, 25'h10, 1'b1, 8'h11);
        push(GNT_DMA, 25'h20, 1'b0, 8'h1C);
        push(GNT_CPU, 25'h11, 1'b1, 8'h22);
        push(GNT_DMA, 25'h21, 1'b0, 8'h1D);
        fork
            begin xfer(GNT_CPU, 25'h10, 1'b1, 8'h11, l0); xfer(GNT_CPU, 25'h11, 1'b1, 8'h22, l0); end
            begin xfer(GNT_DMA, 25'h20, 1'b0, 8'h00, l1); xfer(GNT_DMA, 25'h21, 1'b0, 8'h00, l1); end
        join

        // downloading: only dl is served; dropping it mid-slot still acks that slot, then cpu goes first
        downloading = 1'b1;
        push(GNT_DL, 25'h30, 1'b1, 8'h01);
        push(GNT_DL, 25'h31, 1'b1, 8'h02);
        push(GNT_CPU, 25'h40, 1'b0, 8'h7C);
        push(GNT_DMA, 25'h50, 1'b0, 8'h6C);
        fork
            begin xfer(GNT_DL, 25'h30, 1'b1, 8'h01, l0); xfer(GNT_DL, 25'h31, 1'b1, 8'h02, l0); end
            xfer(GNT_CPU, 25'h40, 1'b0, 8'h00, l1);
            xfer(GNT_DMA, 25'h50, 1'b0, 8'h00, l2);
            begin
                n = 0;
                while (!dl_ack && n < 400) begin @(posedge clk); #1; n++; end
                n = 0;
                while (!(sd_we && grant == GNT_DL) && n < 400) begin @(posedge clk); #1; n++; end
                repeat (3) @(posedge clk);
                #1 downloading = 1'b0;
            end
        join

        // dl_req is ignored while downloading is low
        dl_addr = 25'h99; dl_data = 8'hEE; dl_req = 1'b1;
        push(GNT_CPU, 25'h45, 1'b1, 8'h5A);
        xfer(GNT_CPU, 25'h45, 1'b1, 8'h5A, lat);
        dl_req = 1'b0;

        // reset during cycle 4 of a cpu write slot
        cpu_addr = 25'h60; cpu_we = 1'b1; cpu_wdata = 8'h66; cpu_req = 1'b1;
        n = 0; t = 0;
        while (n < 4 && t < 400) begin
            @(negedge clk);
            t++;
            n = (sd_we && grant == GNT_CPU) ? n + 1 : 0;
        end
        chk("slot_reached", 32'(n), 32'd4);
        reset_n = 1'b0;
        #1;
        chk("reset_strobes", 32'({sd_we, sd_oe, sd_refresh}), 32'd0);
        chk("reset_grant", 32'(grant), 32'd0);
        cpu_req = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;
        a = 0;
        repeat (14) begin @(posedge clk); #1; a += 32'(dl_ack) + 32'(cpu_ack) + 32'(dma_ack); end
        chk("no_ack_after_reset", 32'(a), 32'd0);
        chk("idle_after_reset", 32'({grant, sd_we, sd_oe}), 32'd0);

        // after reset the round-robin pointer favours cpu on a tie
        push(GNT_CPU, 25'h70, 1'b1, 8'h99);
        push(GNT_DMA, 25'h80, 1'b0, 8'hBC);
        fork
            xfer(GNT_CPU, 25'h70, 1'b1, 8'h99, l0);
            xfer(GNT_DMA, 25'h80, 1'b0, 8'h00, l1);
        join

        // continuous cpu reads; refresh slots interleave only in the refresh build
        for (int i = 0; i < 6; i++) begin
            push(GNT_CPU, 25'h100 + 25'(i), 1'b0, 8'(i) ^ 8'h3C);
            xfer(GNT_CPU, 25'h100 + 25'(i), 1'b0, 8'h00, lat);
        end

        n = 0;
        while (q.size() > 0 && n < 400) begin @(posedge clk); n++; end
        repeat (2) @(posedge clk);
        #1;
        chk("queue_drained", 32'(q.size()), 32'd0);
`ifdef SDRAM_ARB_REFRESH_EN
        chk("refresh_seen", 32'(nref >= 2), 32'd1);
`else
        chk("refresh_never", 32'(ref_hi), 32'd0);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
